// File: rtl/fmdll_fb_div_if.sv
// FMDLL feedback divider configuration handshake.
// Master requests a new N/M; slave answers with ready/err.
interface fmdll_fb_div_if;
  logic [3:0] N;
  logic [1:0] M;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_err;

  modport master (
    output N, M, cfg_valid,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  N, M, cfg_valid,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/fmdll_fb_div.sv
// FMDLL feedback divider: divides clk_out by N<<M and
// measures clk_out cycles per ref_in period for lock.
module fmdll_fb_div #(
  parameter logic [3:0] N_RST    = 4'd10,
  parameter logic [1:0] M_RST    = 2'd3,
  parameter int         TOL      = 2,
  parameter int         LOCK_CNT = 4
) (
  input  logic          clk_out,
  input  logic          rst_n,
  fmdll_fb_div_if.slave cfg,
  input  logic          ref_in,
  output logic          clk_div,
  output logic          div_tick,
  output logic [7:0]    meas,
  output logic          lock
);

  localparam logic [6:0] D_RST = {3'b000, N_RST} << M_RST;
  localparam int MCW = $clog2(LOCK_CNT + 1);

  logic [6:0] r_d;
  logic [6:0] r_d_new;
  logic [6:0] r_cnt;
  logic       r_clk_div;
  logic       r_pending;
  logic       r_err;

  logic       w_tick;
  logic       w_apply;
  logic       w_req;
  logic       w_accept;
  logic       w_reject;
  logic [6:0] w_d_nxt;
  logic [6:0] w_cnt_nxt;
  logic [7:0] w_half;

  assign w_tick    = (r_cnt == r_d - 7'd1);
  assign w_apply   = r_pending & w_tick;
  assign w_req     = cfg.cfg_valid & ~r_pending;
  assign w_accept  = w_req & (cfg.N != 4'd0);
  assign w_reject  = w_req & (cfg.N == 4'd0);
  assign w_d_nxt   = w_apply ? r_d_new : r_d;
  assign w_cnt_nxt = w_tick ? 7'd0 : r_cnt + 7'd1;
  assign w_half    = ({1'b0, w_d_nxt} + 8'd1) >> 1;

  // clk_div is computed for the next count so it lines up with r_cnt
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      r_d       <= D_RST;
      r_cnt     <= 7'd0;
      r_clk_div <= 1'b1;
    end else begin
      r_d       <= w_d_nxt;
      r_cnt     <= w_cnt_nxt;
      r_clk_div <= ({1'b0, w_cnt_nxt} < w_half);
    end
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      r_d_new   <= D_RST;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_apply) begin
        r_pending <= 1'b0;
      end else if (w_accept) begin
        r_pending <= 1'b1;
        r_d_new   <= {3'b000, cfg.N} << cfg.M;
      end
    end
  end

  assign cfg.cfg_ready = ~r_pending;
  assign cfg.cfg_err   = r_err;
  assign clk_div       = r_clk_div;
  assign div_tick      = w_tick;

  logic           r_s1;
  logic           r_s2;
  logic           r_s3;
  logic [7:0]     r_mcnt;
  logic [7:0]     r_meas;
  logic           r_first;
  logic [MCW-1:0] r_mc;
  logic           r_lock;

  logic           w_rise;
  logic [7:0]     w_meas_new;
  logic           w_match;
  logic [MCW-1:0] w_mc_inc;

  assign w_rise     = r_s2 & ~r_s3;
  assign w_meas_new = (r_mcnt == 8'hFF) ? 8'hFF : r_mcnt + 8'd1;
  assign w_match    = (w_meas_new != 8'hFF)
                    && ({1'b0, w_meas_new} + 9'(TOL) >= {2'b00, r_d})
                    && ({1'b0, w_meas_new} <= {2'b00, r_d} + 9'(TOL));
  assign w_mc_inc   = (r_mc == MCW'(LOCK_CNT)) ? r_mc : r_mc + 1'b1;

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= ref_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // First edge after reset or apply only restarts the period count
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      r_mcnt  <= 8'd0;
      r_meas  <= 8'd0;
      r_first <= 1'b1;
      r_mc    <= '0;
      r_lock  <= 1'b0;
    end else begin
      r_mcnt <= w_rise ? 8'd0 : w_meas_new;
      if (w_apply) begin
        r_first <= 1'b1;
        r_mc    <= '0;
        r_lock  <= 1'b0;
      end else if (w_rise) begin
        r_first <= 1'b0;
        if (!r_first) begin
          r_meas <= w_meas_new;
          if (w_match) begin
            r_mc   <= w_mc_inc;
            r_lock <= (w_mc_inc == MCW'(LOCK_CNT));
          end else begin
            r_mc   <= '0;
            r_lock <= 1'b0;
          end
        end
      end
    end
  end

  assign meas = r_meas;
  assign lock = r_lock;

endmodule

// File: tb/tb_fmdll_fb_div.sv
// Bench for fmdll_fb_div: directed stimulus, expected values
// queued into a scoreboard and popped by monitor processes.
module tb_fmdll_fb_div;

  logic       clk;
  logic       rst_n;
  logic       ref_in;
  logic       clk_div;
  logic       div_tick;
  logic [7:0] meas;
  logic       lock;

  fmdll_fb_div_if cfg ();

  fmdll_fb_div dut (
    .clk_out  (clk),
    .rst_n    (rst_n),
    .cfg      (cfg),
    .ref_in   (ref_in),
    .clk_div  (clk_div),
    .div_tick (div_tick),
    .meas     (meas),
    .lock     (lock)
  );

  localparam int S_MEAS = 0;
  localparam int S_LOCK = 1;
  localparam int S_RDY  = 2;
  localparam int S_ERR  = 3;

  typedef struct {
    int    cyc;
    int    sel;
    int    exp;
    string name;
  } exp_t;

  typedef struct {
    int hi;
    int lo;
  } div_t;

  exp_t sq[$];
  div_t dq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int m_d = 80;
  int m_first = 1;
  int m_mc = 0;
  int m_lock = 0;
  int m_meas = 0;
  int last_rise = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int sig(int s);
    case (s)
      S_MEAS:  return int'(meas);
      S_LOCK:  return int'(lock);
      S_RDY:   return int'(cfg.cfg_ready);
      S_ERR:   return int'(cfg.cfg_err);
      default: return int'(clk_div);
    endcase
  endfunction

  task automatic push(int c, int s, int v, string nm);
    exp_t e;
    e.cyc  = c;
    e.sel  = s;
    e.exp  = v;
    e.name = nm;
    sq.push_back(e);
  endtask

  task automatic push_div(int hi, int lo);
    div_t d;
    d.hi = hi;
    d.lo = lo;
    dq.push_back(d);
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      e = sq.pop_front();
      check(e.name, sig(e.sel), e.exp);
    end
  end

  // Measures high/low run of clk_div over each divider period
  initial begin
    int hi = 0;
    int lo = 0;
    div_t d;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hi = 0;
        lo = 0;
      end else begin
        if (clk_div) hi++;
        else lo++;
        if (div_tick) begin
          if (dq.size() > 0) begin
            d = dq.pop_front();
            check("div_hi", hi, d.hi);
            check("div_lo", lo, d.lo);
          end
          hi = 0;
          lo = 0;
        end
      end
    end
  end

  task automatic model_edge(int r);
    int gap;
    gap = r - last_rise;
    last_rise = r;
    if (m_first != 0) begin
      m_first = 0;
    end else begin
      m_meas = (gap >= 255) ? 255 : gap;
      if (m_meas != 255 && m_meas <= m_d + 2 && m_meas + 2 >= m_d) begin
        if (m_mc < 4) m_mc++;
      end else begin
        m_mc = 0;
      end
      m_lock = (m_mc == 4) ? 1 : 0;
    end
    push(r + 5, S_MEAS, m_meas, "meas");
    push(r + 5, S_LOCK, m_lock, "lock");
  endtask

  task automatic gen_edges(int p, int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      ref_in = 1'b1;
      model_edge(cyc);
      repeat (p / 2) @(posedge clk);
      #2;
      ref_in = 1'b0;
      repeat (p - p / 2 - 1) @(posedge clk);
    end
  endtask

  task automatic wait_tick();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!div_tick && k < 300);
    check("tick_timeout", int'(div_tick), 1);
    #1;
  endtask

  task automatic wait_apply(int newd);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cfg.cfg_ready && k < 300);
    check("apply_timeout", int'(cfg.cfg_ready), 1);
    m_d = newd;
    m_first = 1;
    m_mc = 0;
    m_lock = 0;
    push(cyc, S_LOCK, 0, "lock_apply");
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((sq.size() > 0 || dq.size() > 0) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("drain", sq.size() + dq.size(), 0);
  endtask

  // kind: 0 accepted, 1 rejected, 2 ignored while pending
  task automatic cfg_req(logic [3:0] n, logic [1:0] m, int kind);
    int c;
    @(negedge clk);
    c = cyc;
    cfg.N = n;
    cfg.M = m;
    cfg.cfg_valid = 1'b1;
    case (kind)
      0: begin
        push(c + 1, S_RDY, 0, "rdy_acc");
        push(c + 1, S_ERR, 0, "err_acc");
      end
      1: begin
        push(c + 1, S_ERR, 1, "err_rej");
        push(c + 1, S_RDY, 1, "rdy_rej");
        push(c + 2, S_ERR, 0, "err_pulse");
      end
      default: begin
        push(c + 1, S_ERR, 0, "err_ign");
        push(c + 1, S_RDY, 0, "rdy_ign");
      end
    endcase
    @(negedge clk);
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic chk_reset(string tag);
    check({tag, "_clk_div"}, int'(clk_div), 1);
    check({tag, "_tick"}, int'(div_tick), 0);
    check({tag, "_rdy"}, int'(cfg.cfg_ready), 1);
    check({tag, "_err"}, int'(cfg.cfg_err), 0);
    check({tag, "_meas"}, int'(meas), 0);
    check({tag, "_lock"}, int'(lock), 0);
  endtask

  task automatic model_reset();
    m_d = 80;
    m_first = 1;
    m_mc = 0;
    m_lock = 0;
    m_meas = 0;
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    ref_in = 1'b0;
    cfg.N = 4'd0;
    cfg.M = 2'd0;
    cfg.cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    rst_n = 1'b1;

    wait_tick();
    push_div(40, 40);
    push_div(40, 40);
    gen_edges(80, 5);

    gen_edges(79, 1);
    gen_edges(81, 1);
    gen_edges(79, 1);
    gen_edges(81, 1);
    gen_edges(84, 1);
    gen_edges(80, 1);

    repeat (300) @(posedge clk);
    gen_edges(80, 5);
    wait_drain();

    cfg_req(4'd0, 2'd2, 1);
    wait_tick();
    push_div(40, 40);
    wait_drain();

    wait_tick();
    cfg_req(4'd5, 2'd1, 0);
    cfg_req(4'd0, 2'd0, 2);
    wait_apply(10);
    push_div(5, 5);
    push_div(5, 5);
    gen_edges(10, 5);
    wait_drain();

    wait_tick();
    cfg_req(4'd2, 2'd0, 0);
    repeat (2) @(negedge clk);
    check("rdy_pending", int'(cfg.cfg_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("rst1");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_tick();
    check("rdy_after_rst", int'(cfg.cfg_ready), 1);
    push_div(40, 40);
    gen_edges(80, 2);
    wait_drain();

    // Request lands on a div_tick cycle: old period runs once more
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!div_tick && k < 300);
    check("tick_timeout", int'(div_tick), 1);
    cfg.N = 4'd15;
    cfg.M = 2'd0;
    cfg.cfg_valid = 1'b1;
    #1;
    push_div(40, 40);
    push_div(8, 7);
    push_div(8, 7);
    @(negedge clk);
    cfg.cfg_valid = 1'b0;
    wait_apply(15);
    wait_drain();

    wait_tick();
    cfg_req(4'd1, 2'd0, 0);
    wait_apply(1);
    push_div(1, 0);
    push_div(1, 0);
    push_div(1, 0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
